// File: rtl/axil_intc_pkg.sv
// Shared constants for the AXI-Lite priority interrupt controller:
// register word offsets, response codes, bus FSM states and small decode helpers.
package axil_intc_pkg;

  localparam logic [3:0] REG_ISR  = 4'h0;
  localparam logic [3:0] REG_IPR  = 4'h1;
  localparam logic [3:0] REG_IER  = 4'h2;
  localparam logic [3:0] REG_IAR  = 4'h3;
  localparam logic [3:0] REG_SIE  = 4'h4;
  localparam logic [3:0] REG_CIE  = 4'h5;
  localparam logic [3:0] REG_IVR  = 4'h6;
  localparam logic [3:0] REG_MER  = 4'h7;
  localparam logic [3:0] REG_MODE = 4'h8;
  localparam logic [3:0] REG_POL  = 4'h9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRESP, RDATA} bus_state_t;

  // Word index past the last register (byte offset 0x28 and up) is an error.
  function automatic logic addr_err(input logic [29:0] word_idx);
    return word_idx > 30'd9;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_prio_intc_if.sv
// AXI4-Lite bundle (32-bit address and data) with Master and Slave views.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Priority encoder: lowest set request bit wins; idx is 0 when nothing is set.
// Purely combinational, no backpressure.
module intc_prio_enc #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic             vld,
  output logic [4:0]       idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    // Walk downwards so the last hit, the lowest index, is what remains.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/axil_prio_intc.sv
// AXI-Lite interrupt controller with level/edge sources, per-source polarity and lowest-index priority.
// ISR updates 1 cycle after irq_i, irq_o 2 cycles; one bus transaction per 2 cycles, B/R held until ready.
module axil_prio_intc
  import axil_intc_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [31:0] EDGE_MASK = 32'hffff_fffe,
  parameter logic [31:0] POL_MASK  = 32'h0
) (
  input  logic             aclk,
  input  logic             aresetn,
  AXI_LITE.Slave           slv,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o,
  output logic [4:0]       irq_id_o
);

  typedef logic [N_IRQ-1:0] vec_t;

  bus_state_t  state;
  vec_t        isr, ier, mode, pol, a_q;
  logic        me;
  vec_t        isr_nxt, ier_nxt, mode_nxt, pol_nxt;
  logic        me_nxt;
  vec_t        act, set_now, soft_set, ack_clr, wbm, wdat, pend;
  logic [31:0] wmask, wmd, rdata_mux;
  logic [3:0]  wsel;
  logic        wr_fire, rd_fire, wr_err, rd_err, enc_vld;
  logic [4:0]  enc_idx;
  logic        unused_ok;

  assign slv.aw_ready = (state == IDLE) && slv.aw_valid && slv.w_valid;
  assign slv.w_ready  = slv.aw_ready;
  assign slv.ar_ready = (state == IDLE) && !(slv.aw_valid && slv.w_valid) && slv.ar_valid;

  assign wr_fire = slv.aw_ready;
  assign rd_fire = slv.ar_ready;
  assign wr_err  = addr_err(slv.aw_addr[31:2]);
  assign rd_err  = addr_err(slv.ar_addr[31:2]);
  assign wsel    = slv.aw_addr[5:2];
  assign wmask   = strb_mask(slv.w_strb);
  assign wmd     = slv.w_data & wmask;
  assign wbm     = wmask[N_IRQ-1:0];
  assign wdat    = wmd[N_IRQ-1:0];

  assign act     = irq_i ^ pol;
  assign set_now = (act & ~mode) | (act & mode & ~a_q);
  assign pend    = isr & ier;

  assign unused_ok = ^{slv.aw_addr[1:0], slv.ar_addr[1:0], wmask, wmd};

  intc_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req (pend),
    .vld (enc_vld),
    .idx (enc_idx)
  );

  always_comb begin
    soft_set = '0;
    ack_clr  = '0;
    ier_nxt  = ier;
    mode_nxt = mode;
    pol_nxt  = pol;
    me_nxt   = me;
    if (wr_fire && !wr_err) begin
      case (wsel)
        REG_ISR:  soft_set = wdat;
        REG_IER:  ier_nxt  = (ier & ~wbm) | wdat;
        REG_IAR:  ack_clr  = wdat;
        REG_SIE:  ier_nxt  = ier | wdat;
        REG_CIE:  ier_nxt  = ier & ~wdat;
        REG_MER:  if (slv.w_strb[0]) me_nxt = slv.w_data[0];
        REG_MODE: mode_nxt = (mode & ~wbm) | wdat;
        REG_POL:  pol_nxt  = (pol & ~wbm) | wdat;
        default:  ;
      endcase
    end
    // A fresh set outranks an acknowledge of the same bit.
    isr_nxt = (isr & ~ack_clr) | set_now | soft_set;
  end

  always_comb begin
    rdata_mux = '0;
    case (slv.ar_addr[5:2])
      REG_ISR:  rdata_mux[N_IRQ-1:0] = isr;
      REG_IPR:  rdata_mux[N_IRQ-1:0] = pend;
      REG_IER:  rdata_mux[N_IRQ-1:0] = ier;
      REG_IVR:  rdata_mux = enc_vld ? {27'd0, enc_idx} : 32'hffff_ffff;
      REG_MER:  rdata_mux[0] = me;
      REG_MODE: rdata_mux[N_IRQ-1:0] = mode;
      REG_POL:  rdata_mux[N_IRQ-1:0] = pol;
      default:  ;
    endcase
    if (rd_err) rdata_mux = '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      slv.b_valid <= 1'b0;
      slv.b_resp  <= RESP_OKAY;
      slv.r_valid <= 1'b0;
      slv.r_data  <= '0;
      slv.r_resp  <= RESP_OKAY;
      isr         <= '0;
      ier         <= '0;
      me          <= 1'b0;
      mode        <= EDGE_MASK[N_IRQ-1:0];
      pol         <= POL_MASK[N_IRQ-1:0];
      a_q         <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
    end else begin
      isr      <= isr_nxt;
      ier      <= ier_nxt;
      me       <= me_nxt;
      mode     <= mode_nxt;
      pol      <= pol_nxt;
      // History is kept under the upcoming polarity so a POL write alone never looks like an edge.
      a_q      <= irq_i ^ pol_nxt;
      irq_o    <= me & (|pend);
      irq_id_o <= enc_idx;
      case (state)
        IDLE: begin
          if (wr_fire) begin
            state       <= WRESP;
            slv.b_valid <= 1'b1;
            slv.b_resp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end else if (rd_fire) begin
            state       <= RDATA;
            slv.r_valid <= 1'b1;
            slv.r_data  <= rdata_mux;
            slv.r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WRESP: begin
          if (slv.b_ready) begin
            state       <= IDLE;
            slv.b_valid <= 1'b0;
          end
        end
        RDATA: begin
          if (slv.r_ready) begin
            state       <= IDLE;
            slv.r_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_prio_intc.sv
// Bench for axil_prio_intc: directed scenarios plus random bus/irq traffic,
// scored against a cycle-level behavioural model of the register set.
module tb_axil_prio_intc;
  import axil_intc_pkg::*;

  localparam int          N      = 8;
  localparam logic [31:0] EDGE_M = 32'hffff_fffe;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [N-1:0] irq_i = '0;
  logic         irq_o;
  logic [4:0]   irq_id_o;
  int           n_vec = 0;
  int           n_err = 0;
  bit           mon_en = 1'b0;

  AXI_LITE slv();

  axil_prio_intc #(.N_IRQ(N)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .slv      (slv),
    .irq_i    (irq_i),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [N-1:0]  m_isr, m_ier, m_mode, m_pol, m_prev_irq;
  bit          m_me, m_prev_vld, m_irq_o;
  int          m_id;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [31:0] d;
    int lo;
    d  = '0;
    lo = lowest(m_isr & m_ier);
    if (addr >= 32'h28) return {RESP_SLVERR, 32'h0};
    case (int'(addr >> 2))
      0: d = 32'(m_isr);
      1: d = 32'(m_isr & m_ier);
      2: d = 32'(m_ier);
      6: d = (lo < 0) ? 32'hffff_ffff : 32'(lo);
      7: d = 32'(m_me);
      8: d = 32'(m_mode);
      9: d = 32'(m_pol);
      default: d = '0;
    endcase
    return {RESP_OKAY, d};
  endfunction

  always @(posedge aclk or negedge aresetn) begin : model
    bit [N-1:0]  set_v, soft_v, clr_v, bm, d;
    bit          act, was, nirq;
    int          lo, ofs;
    logic [31:0] aw;
    if (!aresetn) begin
      m_isr = '0; m_ier = '0; m_me = 1'b0; m_mode = EDGE_M[N-1:0]; m_pol = '0;
      m_prev_vld = 1'b0; m_prev_irq = '0; m_irq_o = 1'b0; m_id = 0;
      rq.delete(); bq.delete();
    end else begin
      set_v = '0; soft_v = '0; clr_v = '0; bm = '0; d = '0;
      if (slv.ar_valid && slv.ar_ready) rq.push_back(model_read(slv.ar_addr));
      for (int i = 0; i < N; i++) begin
        act = irq_i[i] ^ m_pol[i];
        was = m_prev_vld && (m_prev_irq[i] ^ m_pol[i]);
        set_v[i] = m_mode[i] ? (act && !was) : act;
      end
      nirq = m_me && ((m_isr & m_ier) != '0);
      lo   = lowest(m_isr & m_ier);
      if (slv.aw_valid && slv.aw_ready && slv.w_valid && slv.w_ready) begin
        aw = slv.aw_addr;
        for (int i = 0; i < N; i++) bm[i] = slv.w_strb[i / 8];
        d = slv.w_data[N-1:0] & bm;
        if (aw >= 32'h28) bq.push_back(RESP_SLVERR);
        else begin
          bq.push_back(RESP_OKAY);
          ofs = int'(aw >> 2);
          case (ofs)
            0: soft_v = d;
            2: m_ier = (m_ier & ~bm) | d;
            3: clr_v = d;
            4: m_ier = m_ier | d;
            5: m_ier = m_ier & ~d;
            7: if (slv.w_strb[0]) m_me = slv.w_data[0];
            8: m_mode = (m_mode & ~bm) | d;
            9: m_pol = (m_pol & ~bm) | d;
            default: ;
          endcase
        end
      end
      m_isr      = (m_isr & ~clr_v) | set_v | soft_v;
      m_prev_irq = irq_i;
      m_prev_vld = 1'b1;
      m_irq_o    = nirq;
      m_id       = (lo < 0) ? 0 : lo;
    end
  end

  always @(negedge aclk) begin
    if (aresetn && mon_en) begin
      chk("irq_o", 32'(irq_o), 32'(m_irq_o));
      chk("irq_id_o", 32'(irq_id_o), 32'(m_id));
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    logic [1:0] e;
    @(negedge aclk);
    slv.aw_addr = addr; slv.w_data = data; slv.w_strb = strb;
    slv.aw_valid = 1'b1; slv.w_valid = 1'b1; slv.b_ready = 1'b1;
    #1;
    n = 0;
    while (!slv.aw_ready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("aw_ready", 32'(slv.aw_ready), 32'd1);
    if (slv.aw_ready) begin @(posedge aclk); #1; end
    slv.aw_valid = 1'b0; slv.w_valid = 1'b0;
    n = 0;
    while (!slv.b_valid && n < 20) begin @(negedge aclk); n++; end
    chk("b_valid", 32'(slv.b_valid), 32'd1);
    if (slv.b_valid) begin
      e = (bq.size() > 0) ? bq.pop_front() : 2'b11;
      chk("b_resp", 32'(slv.b_resp), 32'(e));
      @(posedge aclk); #1;
    end
    slv.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [33:0] e;
    data = '0; resp = 2'b11;
    @(negedge aclk);
    slv.ar_addr = addr; slv.ar_valid = 1'b1; slv.r_ready = 1'b1;
    #1;
    n = 0;
    while (!slv.ar_ready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("ar_ready", 32'(slv.ar_ready), 32'd1);
    if (slv.ar_ready) begin @(posedge aclk); #1; end
    slv.ar_valid = 1'b0;
    n = 0;
    while (!slv.r_valid && n < 20) begin @(negedge aclk); n++; end
    chk("r_valid", 32'(slv.r_valid), 32'd1);
    if (slv.r_valid) begin
      e = (rq.size() > 0) ? rq.pop_front() : {2'b11, 32'hdead_beef};
      chk("r_resp", 32'(slv.r_resp), 32'(e[33:32]));
      chk("r_data", slv.r_data, e[31:0]);
      data = slv.r_data; resp = slv.r_resp;
      @(posedge aclk); #1;
    end
    slv.r_ready = 1'b0;
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(tag, d, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, rnd, addr;
    logic [1:0]  rsp;
    int          n, sel;
    slv.aw_addr = '0; slv.aw_valid = 1'b0; slv.w_data = '0; slv.w_strb = '0; slv.w_valid = 1'b0;
    slv.b_ready = 1'b0; slv.ar_addr = '0; slv.ar_valid = 1'b0; slv.r_ready = 1'b0;

    repeat (3) @(negedge aclk);
    chk("rst_irq_o", 32'(irq_o), 32'd0);
    chk("rst_irq_id", 32'(irq_id_o), 32'd0);
    chk("rst_b_valid", 32'(slv.b_valid), 32'd0);
    chk("rst_r_valid", 32'(slv.r_valid), 32'd0);
    chk("rst_r_data", slv.r_data, 32'd0);
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // Level source 0
    axi_write(32'h08, 32'h1, 4'hf);
    axi_write(32'h1c, 32'h1, 4'hf);
    @(negedge aclk); irq_i[0] = 1'b1;
    @(negedge aclk); chk("lvl_irq_o_p1", 32'(irq_o), 32'd0);
    @(negedge aclk); chk("lvl_irq_o_p2", 32'(irq_o), 32'd1);
    rd_exp("lvl_isr", 32'h00, 32'h1);
    axi_write(32'h0c, 32'h1, 4'hf);
    rd_exp("lvl_repend", 32'h00, 32'h1);
    @(negedge aclk); irq_i[0] = 1'b0;
    axi_write(32'h0c, 32'h1, 4'hf);
    rd_exp("lvl_cleared", 32'h00, 32'h0);
    chk("lvl_irq_o_off", 32'(irq_o), 32'd0);

    // Edge source 1
    axi_write(32'h08, 32'h2, 4'hf);
    @(negedge aclk); irq_i[1] = 1'b1;
    @(negedge aclk); irq_i[1] = 1'b0;
    rd_exp("edge_isr", 32'h00, 32'h2);
    rd_exp("edge_ivr", 32'h18, 32'h1);
    @(negedge aclk); irq_i[1] = 1'b1;
    repeat (2) @(negedge aclk);
    axi_write(32'h0c, 32'h2, 4'hf);
    rd_exp("edge_no_reset", 32'h00, 32'h0);
    @(negedge aclk); irq_i[1] = 1'b0;

    // Falling edge on source 3
    axi_write(32'h24, 32'h8, 4'hf);
    rd_exp("pol_wr_no_isr", 32'h00, 32'h0);
    @(negedge aclk); irq_i[3] = 1'b1;
    repeat (2) @(negedge aclk);
    rd_exp("pol_rise_idle", 32'h00, 32'h0);
    @(negedge aclk); irq_i[3] = 1'b0;
    repeat (2) @(negedge aclk);
    rd_exp("pol_fall_set", 32'h00, 32'h8);
    axi_write(32'h0c, 32'h8, 4'hf);
    @(negedge aclk); irq_i[3] = 1'b1;
    repeat (2) @(negedge aclk);
    rd_exp("pol_rise_none", 32'h00, 32'h0);
    axi_write(32'h24, 32'h0, 4'hf);
    rd_exp("pol_restore", 32'h00, 32'h0);
    @(negedge aclk); irq_i[3] = 1'b0;

    // Priority among 2, 5, 7
    axi_write(32'h08, 32'ha4, 4'hf);
    @(negedge aclk); irq_i = 8'ha4;
    @(negedge aclk); irq_i = 8'h00;
    repeat (2) @(negedge aclk);
    chk("prio_id_2", 32'(irq_id_o), 32'd2);
    rd_exp("prio_ivr_2", 32'h18, 32'd2);
    axi_write(32'h0c, 32'h4, 4'hf);
    rd_exp("prio_ivr_5", 32'h18, 32'd5);
    axi_write(32'h0c, 32'ha0, 4'hf);
    rd_exp("prio_ivr_none", 32'h18, 32'hffff_ffff);
    chk("prio_id_none", 32'(irq_id_o), 32'd0);

    // Strobes, error region, write-before-read arbitration
    axi_write(32'h08, 32'h0, 4'hf);
    axi_write(32'h08, 32'hffff_ffff, 4'h1);
    rd_exp("ier_strb", 32'h08, 32'hff);
    axi_read(32'h30, d, rsp);
    chk("err_resp", 32'(rsp), 32'(RESP_SLVERR));
    chk("err_data", d, 32'h0);
    axi_write(32'h30, 32'hffff_ffff, 4'hf);
    rd_exp("err_wr_noeff", 32'h08, 32'hff);

    @(negedge aclk);
    slv.aw_addr = 32'h08; slv.w_data = 32'h55; slv.w_strb = 4'hf;
    slv.aw_valid = 1'b1; slv.w_valid = 1'b1; slv.b_ready = 1'b1;
    slv.ar_addr = 32'h08; slv.ar_valid = 1'b1; slv.r_ready = 1'b1;
    #1;
    chk("arb_ar_wait", 32'(slv.ar_ready), 32'd0);
    chk("arb_aw_take", 32'(slv.aw_ready), 32'd1);
    @(posedge aclk); #1;
    slv.aw_valid = 1'b0; slv.w_valid = 1'b0;
    n = 0;
    while (!slv.b_valid && n < 20) begin @(negedge aclk); n++; end
    chk("arb_b_valid", 32'(slv.b_valid), 32'd1);
    chk("arb_wr_first", 32'(slv.r_valid), 32'd0);
    if (bq.size() > 0) chk("arb_b_resp", 32'(slv.b_resp), 32'(bq.pop_front()));
    n = 0;
    #1;
    while (!slv.ar_ready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("arb_ar_ready", 32'(slv.ar_ready), 32'd1);
    @(posedge aclk); #1;
    slv.ar_valid = 1'b0; slv.b_ready = 1'b0;
    n = 0;
    while (!slv.r_valid && n < 20) begin @(negedge aclk); n++; end
    chk("arb_r_valid", 32'(slv.r_valid), 32'd1);
    chk("arb_r_data", slv.r_data, 32'h55);
    if (rq.size() > 0) chk("arb_r_model", slv.r_data, rq.pop_front() & 34'hffff_ffff);
    @(posedge aclk); #1;
    slv.r_ready = 1'b0;

    // Reset while a read response is stalled
    @(negedge aclk); irq_i = 8'h02;
    @(negedge aclk);
    slv.ar_addr = 32'h08; slv.ar_valid = 1'b1; slv.r_ready = 1'b0;
    #1;
    n = 0;
    while (!slv.ar_ready && n < 20) begin @(negedge aclk); #1; n++; end
    @(posedge aclk); #1;
    slv.ar_valid = 1'b0;
    chk("stall_r_valid", 32'(slv.r_valid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_r_valid", 32'(slv.r_valid), 32'd0);
    chk("arst_irq_o", 32'(irq_o), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    rd_exp("rst_isr_edge", 32'h00, 32'h2);
    rd_exp("rst_ipr", 32'h04, 32'h0);
    rd_exp("rst_ier", 32'h08, 32'h0);
    rd_exp("rst_ivr", 32'h18, 32'hffff_ffff);
    rd_exp("rst_mer", 32'h1c, 32'h0);
    rd_exp("rst_mode", 32'h20, 32'hfe);
    rd_exp("rst_pol", 32'h24, 32'h0);
    @(negedge aclk); irq_i = 8'h00;
    axi_write(32'h0c, 32'h2, 4'hf);
    rd_exp("rst_isr_ack", 32'h00, 32'h0);

    // Random traffic
    axi_write(32'h1c, 32'h1, 4'hf);
    for (int it = 0; it < 500; it++) begin
      sel  = $urandom_range(0, 9);
      rnd  = $urandom;
      addr = 32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = 32'h1000_0008;
      if (sel < 4) begin
        @(negedge aclk); irq_i = rnd[N-1:0];
        repeat ($urandom_range(0, 2)) @(negedge aclk);
      end else if (sel < 7) begin
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        axi_read(addr, d, rsp);
      end
    end
    @(negedge aclk); irq_i = '0;
    repeat (4) @(negedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
